// File: rtl/stack_ctrl_if.sv
// Request/response and stack-traffic bundle between the control unit, the
// stack sequencer, the stack pointer register and the data-memory arbiter.
interface stack_ctrl_if;
  logic        push;
  logic        pop;
  logic        load;
  logic [15:0] din;
  logic [15:0] loadVal;
  logic        ready;
  logic        done;
  logic        ovf;
  logic        udf;
  logic [15:0] popData;
  logic [15:0] spQ;
  logic        spEna;
  logic [15:0] spD;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        memWe;
  logic        memRe;
  logic [15:0] memRdata;

  // Master is the surrounding system: control unit, SP register and memory.
  modport master (
    output push, pop, load, din, loadVal, spQ, memRdata,
    input  ready, done, ovf, udf, popData, spEna, spD,
           memAddr, memWdata, memWe, memRe
  );

  modport slave (
    input  push, pop, load, din, loadVal, spQ, memRdata,
    output ready, done, ovf, udf, popData, spEna, spD,
           memAddr, memWdata, memWe, memRe
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack sequencer: downward-growing stack with pre-decrement push,
// post-increment pop, direct SP load and overflow/underflow detection.
module stack_ctrl #(
  parameter logic [15:0] STACK_EMPTY = 16'h0000,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input logic         clk_i,
  input logic         rst_i,
  stack_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PUSH_ADJ, PUSH_WR, POP_RD, POP_ADJ, LOAD_ST, DONE_ST
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] dinLat_q, dinLat_d;
  logic [15:0] loadLat_q, loadLat_d;
  logic [15:0] popData_q, popData_d;
  logic        ovf_q, ovf_d;
  logic        udf_q, udf_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dinLat_q  <= 16'h0000;
      loadLat_q <= 16'h0000;
      popData_q <= 16'h0000;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dinLat_q  <= dinLat_d;
      loadLat_q <= loadLat_d;
      popData_q <= popData_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // SP_Q already reflects any SP_ENA of the previous cycle (falling-edge update).
  always_comb begin
    state_d   = state_q;
    dinLat_d  = dinLat_q;
    loadLat_d = loadLat_q;
    popData_d = popData_q;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          loadLat_d = bus.loadVal;
          state_d   = LOAD_ST;
        end else if (bus.push) begin
          dinLat_d = bus.din;
          if (bus.spQ == STACK_LIMIT) begin
            ovf_d   = 1'b1;
            state_d = DONE_ST;
          end else begin
            state_d = PUSH_ADJ;
          end
        end else if (bus.pop) begin
          if (bus.spQ == STACK_EMPTY) begin
            udf_d   = 1'b1;
            state_d = DONE_ST;
          end else begin
            state_d = POP_RD;
          end
        end
      end
      PUSH_ADJ: state_d = PUSH_WR;
      PUSH_WR:  state_d = DONE_ST;
      POP_RD:   state_d = POP_ADJ;
      POP_ADJ: begin
        popData_d = bus.memRdata;
        state_d   = DONE_ST;
      end
      LOAD_ST:  state_d = DONE_ST;
      DONE_ST:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready    = 1'b0;
    bus.done     = 1'b0;
    bus.ovf      = 1'b0;
    bus.udf      = 1'b0;
    bus.spEna    = 1'b0;
    bus.spD      = 16'h0000;
    bus.memAddr  = 16'h0000;
    bus.memWdata = 16'h0000;
    bus.memWe    = 1'b0;
    bus.memRe    = 1'b0;
    case (state_q)
      IDLE: bus.ready = 1'b1;
      PUSH_ADJ: begin
        bus.spEna = 1'b1;
        bus.spD   = bus.spQ - 16'd1;
      end
      PUSH_WR: begin
        bus.memWe    = 1'b1;
        bus.memAddr  = bus.spQ;
        bus.memWdata = dinLat_q;
      end
      POP_RD: begin
        bus.memRe   = 1'b1;
        bus.memAddr = bus.spQ;
      end
      POP_ADJ: begin
        bus.spEna = 1'b1;
        bus.spD   = bus.spQ + 16'd1;
      end
      LOAD_ST: begin
        bus.spEna = 1'b1;
        bus.spD   = loadLat_q;
      end
      DONE_ST: begin
        bus.done = 1'b1;
        bus.ovf  = ovf_q;
        bus.udf  = udf_q;
      end
      default: bus.ready = 1'b0;
    endcase
  end

  assign bus.popData = popData_q;

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Sequencer for the 16-bit stack pointer register and the data-memory port used for stack traffic. Accepts PUSH/POP/LOAD requests from the control unit and drives the stack pointer register's enable/data inputs and the memory address/strobes. The stack grows downward with pre-decrement push and post-increment pop, and the block flags overflow and underflow. It sits between the control unit, the stack pointer register and the data-memory arbiter.

Parameters:
STACK_EMPTY, 16'h0000, SP value meaning "stack empty"; equals the stack pointer register's reset value.
STACK_LIMIT, 16'hFF00, lowest legal SP; SP == STACK_LIMIT means the stack is full (256 entries by default).

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  reset, synchronous, active-high
PUSH  in  1  push request, sampled only when READY=1
POP  in  1  pop request, sampled only when READY=1
LOAD  in  1  direct SP load request, sampled only when READY=1
DIN  in  16  push data, captured at request acceptance
LOAD_VAL  in  16  SP load value, captured at request acceptance
READY  out  1  idle, can accept a request
DONE  out  1  one-cycle completion pulse
OVF  out  1  push rejected (stack full), pulses with DONE
UDF  out  1  pop rejected (stack empty), pulses with DONE
POP_DATA  out  16  last popped word; holds until next successful pop
SP_Q  in  16  current stack pointer value from the stack pointer register
SP_ENA  out  1  stack pointer register load enable
SP_D  out  16  stack pointer register next value
MEM_ADDR  out  16  stack memory address
MEM_WDATA  out  16  stack write data
MEM_WE  out  1  memory write strobe
MEM_RE  out  1  memory read strobe; MEM_RDATA is valid the following cycle
MEM_RDATA  in  16  memory read data

Behaviour:
- Reset (RST=1 at rising edge): state goes to IDLE. READY=1. DONE, OVF, UDF, SP_ENA, MEM_WE and MEM_RE are 0. SP_D, MEM_ADDR, MEM_WDATA and POP_DATA are 16'h0000. RST overrides any operation in flight. An aborted write or SP update is not completed, and no DONE is issued.
- All outputs are registered or decoded from state only. There is no combinational path from request inputs to outputs.
- States: IDLE, PUSH_ADJ, PUSH_WR, POP_RD, POP_ADJ, LOAD_ST, DONE_ST.
- IDLE: READY=1. Request priority is LOAD > PUSH > POP. Lower-priority requests in the same cycle are dropped, and the requester must reissue. DIN and LOAD_VAL are latched on acceptance.
- LOAD: IDLE -> LOAD_ST (SP_ENA=1, SP_D=latched LOAD_VAL) -> DONE_ST.
- PUSH, SP_Q != STACK_LIMIT: IDLE -> PUSH_ADJ -> PUSH_WR -> DONE_ST.
  - PUSH_ADJ: SP_ENA=1, SP_D=SP_Q-1, modulo 2^16.
  - PUSH_WR: MEM_WE=1, MEM_ADDR=SP_Q (the decremented value), MEM_WDATA=latched DIN.
- PUSH, SP_Q == STACK_LIMIT: IDLE -> DONE_ST with OVF=1. No SP change and no memory access.
- POP, SP_Q != STACK_EMPTY: IDLE -> POP_RD -> POP_ADJ -> DONE_ST.
  - POP_RD: MEM_RE=1, MEM_ADDR=SP_Q.
  - POP_ADJ: POP_DATA<=MEM_RDATA, SP_ENA=1, SP_D=SP_Q+1, modulo 2^16 (FFFF wraps to 0000).
- POP, SP_Q == STACK_EMPTY: IDLE -> DONE_ST with UDF=1. POP_DATA is unchanged and there is no memory access.
- DONE_ST: DONE=1 for exactly one cycle, READY=0, then the state returns to IDLE.
- SP timing: the stack pointer register updates on the falling edge following an SP_ENA cycle. The new SP_Q is therefore stable before the next rising edge, and the state after any SP_ENA state reads the updated value.
- Latency, acceptance edge to DONE high:
  - push or pop: 3 cycles
  - load: 2 cycles
  - OVF/UDF abort: 1 cycle
- SP_ENA, MEM_WE and MEM_RE are never asserted in the same cycle, and each is asserted for exactly one cycle per operation.
- Requests asserted while READY=0 are ignored. They are not queued.

Test Plan:
- Reset, then PUSH with DIN=16'hABCD: PUSH_ADJ drives SP_D=FFFF with SP_ENA=1. Next cycle MEM_WE=1, ADDR=FFFF, WDATA=ABCD. DONE 3 cycles after acceptance. SP_Q=FFFF afterwards.
- Continue with POP while MEM_RDATA=ABCD on the cycle after MEM_RE: MEM_RE=1 at ADDR=FFFF, then SP_D=0000 with SP_ENA=1. POP_DATA=ABCD. DONE with UDF=0. SP_Q=0000.
- POP at SP_Q=0000: DONE and UDF high the cycle after acceptance. No MEM_RE, no SP_ENA. POP_DATA unchanged.
- LOAD_VAL=FF00, then PUSH: SP loads FF00. The push gives OVF=1 and DONE with no MEM_WE. SP_Q stays FF00.
- LOAD, PUSH and POP asserted together in IDLE with LOAD_VAL=1234: only the load executes and SP_Q=1234. PUSH asserted during DONE_ST is ignored.
- RST asserted during PUSH_ADJ: next cycle READY=1, all strobes 0, no MEM_WE and no DONE. SP_Q=0000 (the stack pointer register is also reset).
